// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter: FSM states, the
// read-return tag carried down the latency pipeline, and the word size.
package ram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic isFill;
        logic isLast;
    } rd_tag_t;

    localparam int unsigned WORD_BYTES = 32'd4;

    function automatic rd_tag_t makeTag(input logic valid, input logic isFill, input logic isLast);
        rd_tag_t tag;
        tag.valid  = valid;
        tag.isFill = isFill;
        tag.isLast = isLast;
        return tag;
    endfunction

endpackage

// File: rtl/ram_arb_rd_pipe.sv
// Depth-stage shift register of read-return tags; a tag issued with an
// address emerges on tagOut exactly Depth cycles later, when RAMOut is valid.
module ram_arb_rd_pipe
    import ram_arb_pkg::*;
#(
    parameter int Depth = 1
) (
    input  logic    clock,
    input  logic    reset,
    input  rd_tag_t tagIn,
    output rd_tag_t tagOut,
    output logic    anyValid
);

    rd_tag_t stage_r [Depth];

    // Tag shift chain; reset flushes every in-flight return
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= tagIn;
            for (int i = 1; i < Depth; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    // Any outstanding read keeps the arbiter busy
    always_comb begin
        anyValid = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            anyValid = anyValid | stage_r[i].valid;
        end
    end

    assign tagOut = stage_r[Depth-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Request/grant scheduler sharing one RAM port between the I-cache burst fill
// engine and the load/store path, with a fixed RAM read latency.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 32,
    parameter int BurstLen    = 32,
    parameter int ReadLatency = 0,
    parameter int MaxDataRun  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   FillReq,
    input  logic [RAMAddrSize-1:0] FillAddr,
    output logic                   FillGnt,
    output logic [dataW-1:0]       FillData,
    output logic                   FillValid,
    output logic                   FillLast,
    input  logic                   DReq,
    input  logic                   DWrite,
    input  logic [RAMAddrSize-1:0] DAddr,
    input  logic [dataW-1:0]       DWData,
    output logic                   DGnt,
    output logic [dataW-1:0]       DRData,
    output logic                   DRValid,
    output logic [RAMAddrSize-1:0] RAMAddr,
    output logic [dataW-1:0]       RAMDataIn,
    output logic                   RAMWriteControl,
    input  logic [dataW-1:0]       RAMOut,
    output logic                   Busy
);

    localparam int BeatW = $clog2(BurstLen);
    localparam int RunW  = $clog2(MaxDataRun + 1);
    localparam logic [BeatW-1:0]       LastBeat  = BeatW'(BurstLen - 1);
    localparam logic [RunW-1:0]        RunLimit  = RunW'(MaxDataRun);
    localparam logic [RAMAddrSize-1:0] AlignMask = ~RAMAddrSize'(WORD_BYTES - 32'd1);

    arb_state_t             state_r;
    logic [BeatW-1:0]       beat_r;
    logic [RunW-1:0]        runCnt_r;
    logic [RAMAddrSize-1:0] base_r;

    logic                   grantData_s;
    logic                   grantFill_s;
    logic                   fillBeat_s;
    logic                   lastBeat_s;
    logic [RAMAddrSize-1:0] beatOffset_s;
    logic [RAMAddrSize-1:0] issueAddr_s;
    logic [dataW-1:0]       issueWData_s;
    logic                   issueWrite_s;
    rd_tag_t                issueTag_s;
    rd_tag_t                retTag_s;
    logic                   pipeBusy_s;

    assign fillBeat_s   = (state_r == FILL);
    assign lastBeat_s   = fillBeat_s && (beat_r == LastBeat);
    assign beatOffset_s = RAMAddrSize'(beat_r) * RAMAddrSize'(WORD_BYTES);

    // IDLE arbitration: data wins unless it has starved a pending fill for MaxDataRun grants
    always_comb begin
        grantData_s = 1'b0;
        grantFill_s = 1'b0;
        if (state_r == IDLE) begin
            if (DReq && !(FillReq && (runCnt_r == RunLimit))) begin
                grantData_s = 1'b1;
            end else if (FillReq) begin
                grantFill_s = 1'b1;
            end else begin
                grantData_s = 1'b0;
            end
        end else begin
            grantFill_s = 1'b0;
        end
    end

    // RAM command mux for the single access issued this cycle
    always_comb begin
        issueAddr_s  = '0;
        issueWData_s = '0;
        issueWrite_s = 1'b0;
        if (grantData_s) begin
            issueAddr_s  = DAddr;
            issueWData_s = DWData;
            issueWrite_s = DWrite;
        end else if (grantFill_s) begin
            issueAddr_s = FillAddr & AlignMask;
        end else if (fillBeat_s) begin
            issueAddr_s = base_r + beatOffset_s;
        end else begin
            issueAddr_s = '0;
        end
    end

    assign issueTag_s = makeTag((grantData_s && !DWrite) || grantFill_s || fillBeat_s,
                                grantFill_s || fillBeat_s,
                                lastBeat_s);

    // Scheduler state, burst beat counter, data-run counter and burst base
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            beat_r   <= '0;
            runCnt_r <= '0;
            base_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grantFill_s) begin
                        state_r  <= FILL;
                        beat_r   <= BeatW'(1);
                        runCnt_r <= '0;
                        base_r   <= FillAddr & AlignMask;
                    end else if (grantData_s) begin
                        if (!FillReq) begin
                            runCnt_r <= '0;
                        end else if (runCnt_r != RunLimit) begin
                            runCnt_r <= runCnt_r + RunW'(1);
                        end else begin
                            runCnt_r <= runCnt_r;
                        end
                    end else begin
                        runCnt_r <= runCnt_r;
                    end
                end
                FILL: begin
                    if (beat_r == LastBeat) begin
                        state_r <= IDLE;
                        beat_r  <= '0;
                    end else begin
                        beat_r <= beat_r + BeatW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    beat_r  <= '0;
                end
            endcase
        end
    end

    generate
        if (ReadLatency == 0) begin : g_comb
            assign retTag_s   = issueTag_s;
            assign pipeBusy_s = 1'b0;
        end else begin : g_pipe
            ram_arb_rd_pipe #(.Depth(ReadLatency)) u_rdPipe (
                .clock   (clock),
                .reset   (reset),
                .tagIn   (issueTag_s),
                .tagOut  (retTag_s),
                .anyValid(pipeBusy_s)
            );
        end
    endgenerate

    // Outputs are forced low while reset is held, even for combinational paths
    assign FillGnt         = reset & grantFill_s;
    assign DGnt            = reset & grantData_s;
    assign RAMAddr         = reset ? issueAddr_s : '0;
    assign RAMDataIn       = reset ? issueWData_s : '0;
    assign RAMWriteControl = reset & issueWrite_s;
    assign FillValid       = reset & retTag_s.valid & retTag_s.isFill;
    assign FillLast        = FillValid & retTag_s.isLast;
    assign DRValid         = reset & retTag_s.valid & ~retTag_s.isFill;
    assign FillData        = FillValid ? RAMOut : '0;
    assign DRData          = DRValid ? RAMOut : '0;
    assign Busy            = reset & (fillBeat_s | pipeBusy_s);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: three arbiter configurations (latency 1, latency 2, 8-bit
// addresses with latency 0), each fed by a small behavioural RAM.
module tb_ram_port_arbiter;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hA500_0000 + a;
    endfunction

    // ---- instance A: BurstLen 4, ReadLatency 1, MaxDataRun 4
    logic        fillReqA, fillGntA, fillValidA, fillLastA;
    logic [31:0] fillAddrA, fillDataA;
    logic        dReqA, dWriteA, dGntA, dRValidA;
    logic [31:0] dAddrA, dWDataA, dRDataA;
    logic [31:0] ramAddrA, ramDataInA, ramOutA;
    logic        ramWeA, busyA;
    logic [31:0] wrAddrA, wrDataA;
    logic        wrValidA;

    ram_port_arbiter #(.dataW(32), .RAMAddrSize(32), .BurstLen(4), .ReadLatency(1), .MaxDataRun(4)) dutA (
        .clock(clock), .reset(reset),
        .FillReq(fillReqA), .FillAddr(fillAddrA), .FillGnt(fillGntA), .FillData(fillDataA),
        .FillValid(fillValidA), .FillLast(fillLastA),
        .DReq(dReqA), .DWrite(dWriteA), .DAddr(dAddrA), .DWData(dWDataA),
        .DGnt(dGntA), .DRData(dRDataA), .DRValid(dRValidA),
        .RAMAddr(ramAddrA), .RAMDataIn(ramDataInA), .RAMWriteControl(ramWeA),
        .RAMOut(ramOutA), .Busy(busyA)
    );

    // one-cycle-latency RAM holding a single written word over a pattern
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrValidA <= 1'b0;
            wrAddrA  <= 32'h0;
            wrDataA  <= 32'h0;
            ramOutA  <= 32'h0;
        end else begin
            if (ramWeA) begin
                wrValidA <= 1'b1;
                wrAddrA  <= ramAddrA;
                wrDataA  <= ramDataInA;
            end
            ramOutA <= (wrValidA && wrAddrA == ramAddrA) ? wrDataA : pat(ramAddrA);
        end
    end

    // ---- instance B: BurstLen 4, ReadLatency 2
    logic        fillReqB, fillGntB, fillValidB, fillLastB;
    logic [31:0] fillAddrB, fillDataB;
    logic        dGntB, dRValidB, ramWeB, busyB;
    logic [31:0] dRDataB, ramAddrB, ramDataInB, ramOutB, ramPipeB;

    ram_port_arbiter #(.dataW(32), .RAMAddrSize(32), .BurstLen(4), .ReadLatency(2), .MaxDataRun(4)) dutB (
        .clock(clock), .reset(reset),
        .FillReq(fillReqB), .FillAddr(fillAddrB), .FillGnt(fillGntB), .FillData(fillDataB),
        .FillValid(fillValidB), .FillLast(fillLastB),
        .DReq(1'b0), .DWrite(1'b0), .DAddr(32'h0), .DWData(32'h0),
        .DGnt(dGntB), .DRData(dRDataB), .DRValid(dRValidB),
        .RAMAddr(ramAddrB), .RAMDataIn(ramDataInB), .RAMWriteControl(ramWeB),
        .RAMOut(ramOutB), .Busy(busyB)
    );

    always @(posedge clock) begin
        ramPipeB <= pat(ramAddrB);
        ramOutB  <= ramPipeB;
    end

    // ---- instance C: 8-bit addresses, BurstLen 4, ReadLatency 0
    logic        fillReqC, fillGntC, fillValidC, fillLastC;
    logic [7:0]  fillAddrC, ramAddrC;
    logic [31:0] fillDataC, dRDataC, ramDataInC, ramOutC;
    logic        dGntC, dRValidC, ramWeC, busyC;

    ram_port_arbiter #(.dataW(32), .RAMAddrSize(8), .BurstLen(4), .ReadLatency(0), .MaxDataRun(4)) dutC (
        .clock(clock), .reset(reset),
        .FillReq(fillReqC), .FillAddr(fillAddrC), .FillGnt(fillGntC), .FillData(fillDataC),
        .FillValid(fillValidC), .FillLast(fillLastC),
        .DReq(1'b0), .DWrite(1'b0), .DAddr(8'h00), .DWData(32'h0),
        .DGnt(dGntC), .DRData(dRDataC), .DRValid(dRValidC),
        .RAMAddr(ramAddrC), .RAMDataIn(ramDataInC), .RAMWriteControl(ramWeC),
        .RAMOut(ramOutC), .Busy(busyC)
    );

    assign ramOutC = 32'hA500_0000 + {24'h0, ramAddrC};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        fillReqA = 1'b1; fillAddrA = 32'h20; dReqA = 1'b1; dWriteA = 1'b1;
        step(); step();
        checks++; if ({fillGntA, dGntA, ramWeA, busyA, fillValidA, dRValidA} !== 6'b0)
            begin fails++; $display("FAIL reset_ctrl: got %b expected 000000", {fillGntA, dGntA, ramWeA, busyA, fillValidA, dRValidA}); end
        checks++; if (ramAddrA !== 32'h0 || ramDataInA !== 32'h0)
            begin fails++; $display("FAIL reset_addr: got %h/%h expected 0/0", ramAddrA, ramDataInA); end
        fillReqA = 1'b0; dReqA = 1'b0; dWriteA = 1'b0;
        reset = 1'b1;
        step();
        @(negedge clock);
        checks++; if ({fillGntA, dGntA, ramWeA, busyA} !== 4'b0 || ramAddrA !== 32'h0)
            begin fails++; $display("FAIL idle: got ctl %b addr %h expected 0000 / 0", {fillGntA, dGntA, ramWeA, busyA}, ramAddrA); end
        step();
    endtask

    task automatic test_fill_burst();
        logic [31:0] expAddr;
        fillReqA = 1'b1; fillAddrA = 32'h103;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            expAddr = (k < 4) ? 32'h100 + 32'(4 * k) : 32'h0;
            checks++; if (fillGntA !== (k == 0))
                begin fails++; $display("FAIL fill_gnt c%0d: got %b expected %b", k, fillGntA, (k == 0)); end
            checks++; if (ramAddrA !== expAddr)
                begin fails++; $display("FAIL fill_addr c%0d: got %h expected %h", k, ramAddrA, expAddr); end
            checks++; if (fillValidA !== (k >= 1 && k <= 4) || fillLastA !== (k == 4))
                begin fails++; $display("FAIL fill_valid c%0d: got v%b l%b expected v%b l%b", k, fillValidA, fillLastA, (k >= 1 && k <= 4), (k == 4)); end
            if (k >= 1 && k <= 4) begin
                checks++; if (fillDataA !== pat(32'h100 + 32'(4 * (k - 1))))
                    begin fails++; $display("FAIL fill_data c%0d: got %h expected %h", k, fillDataA, pat(32'h100 + 32'(4 * (k - 1)))); end
            end
            checks++; if (busyA !== (k >= 1 && k <= 4) || ramWeA !== 1'b0)
                begin fails++; $display("FAIL fill_busy c%0d: got busy %b we %b expected %b 0", k, busyA, ramWeA, (k >= 1 && k <= 4)); end
            step();
            if (k == 0) fillReqA = 1'b0;
        end
    endtask

    task automatic test_data_during_fill();
        fillReqA = 1'b1; fillAddrA = 32'h200;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) begin dReqA = 1'b1; dWriteA = 1'b0; dAddrA = 32'h40; end
            @(negedge clock);
            checks++; if (dGntA !== (k == 4))
                begin fails++; $display("FAIL held_dgnt c%0d: got %b expected %b", k, dGntA, (k == 4)); end
            if (k == 4) begin
                checks++; if (ramAddrA !== 32'h40)
                    begin fails++; $display("FAIL held_addr: got %h expected 00000040", ramAddrA); end
            end
            checks++; if (dRValidA !== (k == 5))
                begin fails++; $display("FAIL held_drvalid c%0d: got %b expected %b", k, dRValidA, (k == 5)); end
            if (k == 5) begin
                checks++; if (dRDataA !== pat(32'h40) || fillValidA !== 1'b0)
                    begin fails++; $display("FAIL held_drdata: got %h fv %b expected %h fv 0", dRDataA, fillValidA, pat(32'h40)); end
            end
            step();
            if (k == 0) fillReqA = 1'b0;
            if (k == 4) dReqA = 1'b0;
        end
    endtask

    task automatic test_max_data_run();
        dReqA = 1'b1; dWriteA = 1'b0; dAddrA = 32'h10;
        fillReqA = 1'b1; fillAddrA = 32'h300;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            checks++; if (dGntA !== (k < 4 || k == 8) || fillGntA !== (k == 4))
                begin fails++; $display("FAIL run c%0d: got dgnt %b fgnt %b expected %b %b", k, dGntA, fillGntA, (k < 4 || k == 8), (k == 4)); end
            step();
            if (k == 4) fillReqA = 1'b0;
            if (k == 8) dReqA = 1'b0;
        end
        step(); step();
    endtask

    task automatic test_store_load();
        dReqA = 1'b1; dWriteA = 1'b1; dAddrA = 32'h80; dWDataA = 32'hDEADBEEF;
        @(negedge clock);
        checks++; if (dGntA !== 1'b1 || ramWeA !== 1'b1 || ramAddrA !== 32'h80 || ramDataInA !== 32'hDEADBEEF)
            begin fails++; $display("FAIL store_issue: got g%b we%b %h %h expected 1 1 00000080 deadbeef", dGntA, ramWeA, ramAddrA, ramDataInA); end
        step();
        dReqA = 1'b0; dWriteA = 1'b0; dWDataA = 32'h0;
        @(negedge clock);
        checks++; if (ramWeA !== 1'b0 || dRValidA !== 1'b0)
            begin fails++; $display("FAIL store_after: got we %b drvalid %b expected 0 0", ramWeA, dRValidA); end
        step();
        dReqA = 1'b1; dAddrA = 32'h80;
        @(negedge clock);
        checks++; if (dGntA !== 1'b1 || ramWeA !== 1'b0)
            begin fails++; $display("FAIL load_issue: got g%b we%b expected 1 0", dGntA, ramWeA); end
        step();
        dReqA = 1'b0;
        @(negedge clock);
        checks++; if (dRValidA !== 1'b1 || dRDataA !== 32'hDEADBEEF)
            begin fails++; $display("FAIL load_back: got v%b %h expected 1 deadbeef", dRValidA, dRDataA); end
        step();
    endtask

    task automatic test_reset_mid_burst();
        fillReqB = 1'b1; fillAddrB = 32'h400;
        @(negedge clock);
        checks++; if (fillGntB !== 1'b1)
            begin fails++; $display("FAIL b_gnt: got %b expected 1", fillGntB); end
        step(); fillReqB = 1'b0;
        step();
        @(negedge clock);
        checks++; if (ramAddrB !== 32'h408 || fillValidB !== 1'b1 || fillDataB !== pat(32'h400))
            begin fails++; $display("FAIL b_beat2: got %h v%b %h expected 00000408 1 %h", ramAddrB, fillValidB, fillDataB, pat(32'h400)); end
        #1 reset = 1'b0;
        #1;
        checks++; if ({fillGntB, fillValidB, fillLastB, dGntB, dRValidB, ramWeB, busyB} !== 7'b0 || ramAddrB !== 32'h0 || fillDataB !== 32'h0)
            begin fails++; $display("FAIL b_reset: got ctl %b addr %h data %h expected 0", {fillGntB, fillValidB, fillLastB, dGntB, dRValidB, ramWeB, busyB}, ramAddrB, fillDataB); end
        @(posedge clock); @(posedge clock);
        #1 reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++; if (fillValidB !== 1'b0 || busyB !== 1'b0 || ramAddrB !== 32'h0)
                begin fails++; $display("FAIL b_flushed c%0d: got v%b busy%b %h expected 0 0 0", k, fillValidB, busyB, ramAddrB); end
            step();
        end
        fillReqB = 1'b1; fillAddrB = 32'h500;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            checks++; if (fillGntB !== (k == 0) || ramAddrB !== ((k < 4) ? 32'h500 + 32'(4 * k) : 32'h0))
                begin fails++; $display("FAIL b_restart c%0d: got g%b %h", k, fillGntB, ramAddrB); end
            checks++; if (fillValidB !== (k >= 2) || fillLastB !== (k == 5))
                begin fails++; $display("FAIL b_ret c%0d: got v%b l%b expected v%b l%b", k, fillValidB, fillLastB, (k >= 2), (k == 5)); end
            if (k >= 2) begin
                checks++; if (fillDataB !== pat(32'h500 + 32'(4 * (k - 2))))
                    begin fails++; $display("FAIL b_data c%0d: got %h expected %h", k, fillDataB, pat(32'h500 + 32'(4 * (k - 2)))); end
            end
            step();
            if (k == 0) fillReqB = 1'b0;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] expC [4];
        expC = '{8'hF8, 8'hFC, 8'h00, 8'h04};
        fillReqC = 1'b1; fillAddrC = 8'hF8;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++; if (ramAddrC !== expC[k])
                begin fails++; $display("FAIL wrap_addr c%0d: got %h expected %h", k, ramAddrC, expC[k]); end
            checks++; if (fillValidC !== 1'b1 || fillLastC !== (k == 3) || fillDataC !== 32'hA500_0000 + {24'h0, expC[k]})
                begin fails++; $display("FAIL wrap_ret c%0d: got v%b l%b %h", k, fillValidC, fillLastC, fillDataC); end
            step();
            if (k == 0) fillReqC = 1'b0;
        end
        @(negedge clock);
        checks++; if (ramAddrC !== 8'h00 || busyC !== 1'b0 || fillValidC !== 1'b0)
            begin fails++; $display("FAIL wrap_end: got %h busy%b v%b expected 00 0 0", ramAddrC, busyC, fillValidC); end
        step();
    endtask

    initial begin
        reset = 1'b0;
        fillReqA = 1'b0; fillAddrA = 32'h0; dReqA = 1'b0; dWriteA = 1'b0; dAddrA = 32'h0; dWDataA = 32'h0;
        fillReqB = 1'b0; fillAddrB = 32'h0;
        fillReqC = 1'b0; fillAddrC = 8'h00;
        test_reset();
        test_fill_burst();
        test_data_during_fill();
        test_max_data_run();
        test_store_load();
        test_reset_mid_burst();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
